// File: rtl/mux_4x1_pkg.sv
// Shared select encoding for the 4:1 multiplexer.
package mux_4x1_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4x1_if.sv
// Select, data and output bundle of the 4:1 multiplexer.
interface mux_4x1_if #(
  parameter int unsigned WIDTH = 1
);

  logic             S0;
  logic             S1;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  modport master (
    output S0, S1, i0, i1, i2, i3,
    input  out, out_q
  );

  modport slave (
    input  S0, S1, i0, i1, i2, i3,
    output out, out_q
  );

endinterface

// File: rtl/mux_4x1_core.sv
// Combinational 4:1 selection; an unknown select drives the output all-X so faults stay visible.
module mux_4x1_core
  import mux_4x1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_s0,
  input  logic             i_s1,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_out
);

  logic [1:0] w_sel;

  assign w_sel = {i_s1, i_s0};

  always_comb begin
    o_out = '0;
    unique case (w_sel)
      SEL_I0:  o_out = i_d0;
      SEL_I1:  o_out = i_d1;
      SEL_I2:  o_out = i_d2;
      SEL_I3:  o_out = i_d3;
      // Only reachable with X/Z on a select bit.
      default: o_out = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux_4x1.sv
// 4:1 multiplexer with combinational output and a registered copy cleared by async reset.
module mux_4x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_4x1_if.slave bus
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;

  mux_4x1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_s0  (bus.S0),
    .i_s1  (bus.S1),
    .i_d0  (bus.i0),
    .i_d1  (bus.i1),
    .i_d2  (bus.i2),
    .i_d3  (bus.i3),
    .o_out (w_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign bus.out   = w_out;
  assign bus.out_q = r_out_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Directed and random checks of mux_4x1 against an array-indexed reference model.
module tb_mux_4x1;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_4x1_if #(.WIDTH(W)) bus ();

  mux_4x1 #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] d [4];
  bit           sel1;
  bit           sel0;
  logic [W-1:0] exp_q;
  logic         xprobe;

  function automatic logic [W-1:0] model_out();
    return d[2 * int'(sel1) + int'(sel0)];
  endfunction

  task automatic drive(input bit s1, input bit s0, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] e);
    sel1 = s1;
    sel0 = s0;
    d[0] = a;
    d[1] = b;
    d[2] = c;
    d[3] = e;
    bus.S1 = s1;
    bus.S0 = s0;
    bus.i0 = a;
    bus.i1 = b;
    bus.i2 = c;
    bus.i3 = e;
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register model: captures the pre-edge selection unless reset is held.
  task automatic tick();
    logic [W-1:0] nxt;
    nxt = model_out();
    @(posedge clk);
    #1;
    exp_q = rst_n ? nxt : '0;
  endtask

  initial begin
    rst_n = 1'b0;
    exp_q = '0;

    drive(1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    check("out_valid_in_reset", bus.out, model_out());
    check("reset_q", bus.out_q, exp_q);
    tick();
    check("reset_hold_q", bus.out_q, exp_q);

    #2 rst_n = 1'b1;
    tick();
    check("first_edge_q", bus.out_q, exp_q);

    drive(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    check("sel01_zero", bus.out, model_out());
    drive(1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h00);
    check("sel01_no_clk_track", bus.out, model_out());

    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 8'h00);
    check("sel10", bus.out, model_out());
    drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01);
    check("sel11", bus.out, model_out());
    drive(1'b1, 1'b1, 8'hff, 8'hff, 8'hff, 8'h01);
    check("nonsel_toggle", bus.out, 8'h01);
    tick();
    check("sel11_q", bus.out_q, exp_q);

    drive(1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    tick();
    check("pre_rst_q", bus.out_q, exp_q);
    #1 rst_n = 1'b0;
    exp_q = '0;
    #1;
    check("async_rst_q", bus.out_q, exp_q);
    tick();
    check("rst_hold_q", bus.out_q, exp_q);
    drive(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01);
    check("out_tracks_in_rst", bus.out, model_out());
    tick();
    check("rst_hold_q2", bus.out_q, exp_q);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    tick();
    check("post_rst_q", bus.out_q, exp_q);

    for (int k = 0; k < 4; k++) begin
      drive(k[1], k[0], 8'h11, 8'h22, 8'h33, 8'h44);
      check("sweep_out", bus.out, model_out());
      check("sweep_q_lag", bus.out_q, exp_q);
      tick();
      check("sweep_q", bus.out_q, exp_q);
    end

    for (int n = 0; n < 40; n++) begin
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), W'($urandom),
            W'($urandom), W'($urandom), W'($urandom));
      check("rand_out", bus.out, model_out());
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        exp_q = '0;
        #1;
        check("rand_async_rst", bus.out_q, exp_q);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
      check("rand_q", bus.out_q, exp_q);
    end

    xprobe = 1'bx;
    if ($isunknown(xprobe)) begin
      bus.S0 = 1'bx;
      #1;
      check("sel_x_out", bus.out, {W{1'bx}});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Four-input, single-select multiplexer with a combinational output and a registered copy of the same selection.
- Two select bits, S1 (MSB) and S0 (LSB), choose one of four data inputs i0..i3.
- Basic-gate building block, used as a leaf cell in datapath steering logic.
- The combinational path serves glue logic; the registered path serves timing-closed consumers.

Parameters:
- WIDTH, default 1, bit width of each data input and of both outputs.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous, active-low reset.
- S0  input  1  select LSB.
- S1  input  1  select MSB.
- i0  input  WIDTH  data input, selected when {S1,S0}=2'b00.
- i1  input  WIDTH  data input, selected when {S1,S0}=2'b01.
- i2  input  WIDTH  data input, selected when {S1,S0}=2'b10.
- i3  input  WIDTH  data input, selected when {S1,S0}=2'b11.
- out  output  WIDTH  combinational selection.
- out_q  output  WIDTH  registered selection, one clk later.

Behaviour:
- Select index is {S1,S0}:
  - 00 -> i0
  - 01 -> i1
  - 10 -> i2
  - 11 -> i3
- out is purely combinational, zero cycle latency, with no dependency on clk or rst_n.
  - out must follow input changes within the same delta or timestep.
  - out is valid even while rst_n=0.
- X/Z on either select bit: out is driven all-X. No silent default to i0, so that select faults are visible in simulation.
- out_q:
  - On the rising edge of clk, out_q <= the value out presents just before the edge.
  - Latency is exactly 1 cycle.
- Reset:
  - rst_n low forces out_q to all-zero immediately, independent of clk.
  - out_q holds zero for as long as rst_n is low.
  - On the first rising clk edge after rst_n deasserts, out_q captures the current selection.
  - Reset deasserted mid-operation needs no special handling; there is no state other than out_q.
- Select and data changing on the same edge: out_q captures the pre-edge values. Normal setup/hold rules apply.
- WIDTH applies bitwise. Every bit of the selected input appears unmodified on out; no sign or zero extension.
- The design contains no latches and no internal state other than the WIDTH-bit out_q register.

Decomposition:
- Shared package holds the 2-bit select encoding constants: SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11.
- One sub-module is natural: mux_4x1_core.
  - Purely combinational, parameterised on WIDTH, implements the selection and the X-propagation rule.
  - The top instantiates it and adds the out_q register with async reset.

Test Plan:
- S1=0, S0=0, i0=1, i1=0, i2=0, i3=0 -> out=1 immediately; out_q=1 after the next rising clk edge.
- S1=0, S0=1, all inputs 0 -> out=0; then i1=1 with the select unchanged -> out=1 with no clock edge needed.
- S1=1, S0=0, i2=1, others 0 -> out=1. S1=1, S0=1, i3=1, others 0 -> out=1. Toggling any non-selected input leaves out unchanged.
- rst_n=0 asserted asynchronously with out=1 -> out_q=0 at once and stays 0 across clk edges, while out still tracks the select. After rst_n=1 -> out_q=1 at the first edge.
- WIDTH=8, i0=8'h11, i1=8'h22, i2=8'h33, i3=8'h44, select swept 00..11 on successive cycles -> out=11, 22, 33, 44; out_q shows the same sequence one cycle late.
- S0=X -> out all-X.
